alu_arbiter: RTL

- Shares one combinational 8-bit ALU between NREQ requesters.
  - ALU interface: operands a, b; 3-bit op select s; result z.
- Round-robin arbitration, operand/op latching, ALU drive, registered result with valid/ready handshake.
- Sits between the requesting blocks and the ALU instance; one operation in flight at a time.

---
 rtl/alu_arbiter_if.sv | 33 +++
 rtl/alu_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Requester/ALU-facing bundle for alu_arbiter: request slices, grant, ALU drive and
// the registered response handshake.
interface alu_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int IW   = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ*3-1:0]  req_op;
    logic [NREQ-1:0]    gnt;
    logic [DW-1:0]      alu_a;
    logic [DW-1:0]      alu_b;
    logic [2:0]         alu_s;
    logic [DW-1:0]      alu_z;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DW-1:0]      rsp_data;
    logic [IW-1:0]      rsp_id;
    logic               busy;

    // master: requesters plus the ALU instance; slave: the arbiter
    modport master (
        output req, req_a, req_b, req_op, rsp_ready, alu_z,
        input  gnt, alu_a, alu_b, alu_s, rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req, req_a, req_b, req_op, rsp_ready, alu_z,
        output gnt, alu_a, alu_b, alu_s, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters.
// Optional ALU_ARB_STATS_EN adds the op_cnt completion counter and stall flag.
module alu_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int IW   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]  op_cnt,
    output logic         stall
`endif
);

    // state | meaning
    // IDLE  | searching req from ptr; grant and latch operands on a hit
    // EXEC  | gnt pulse, ALU settling on latched operands
    // RESP  | result held on rsp_* until rsp_ready
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state, state_next;
    logic [IW-1:0] ptr, win, ptr_next;
    logic [IW:0]   idx;
    logic          found;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
            if (!found && bus.req[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

    assign ptr_next = (win == IW'(NREQ-1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= '0;
            bus.gnt       <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_s     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_id    <= '0;
        end else begin
            bus.gnt <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        bus.gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                        bus.alu_a  <= bus.req_a[win*DW +: DW];
                        bus.alu_b  <= bus.req_b[win*DW +: DW];
                        bus.alu_s  <= bus.req_op[win*3 +: 3];
                        bus.rsp_id <= win;
                        ptr        <= ptr_next;
                    end
                end
                EXEC: begin
                    bus.rsp_data  <= bus.alu_z;
                    bus.rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              op_cnt <= '0;
        else if (state == RESP && bus.rsp_ready) op_cnt <= op_cnt + 16'd1;
    end

    assign stall = (bus.req != '0) && (state != IDLE);
`endif

endmodule
